// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the fetch side (I) and the
// load/store side (D) of the pipeline. One access is in flight at a time:
// the arbiter picks a requester while idle, holds the memory request until
// the memory acknowledges, registers the returned data and pulses the
// requester's ready for one cycle. The pipeline stall is derived directly
// from the two request levels and the two ready pulses.
//
// Parameters
//   AW       address width
//   DW       data width (byte mask is DW/8 bits)
//   TIMEOUT  grant cycles without mem_ack before the access is aborted;
//            0 disables the watchdog
//
// Optional feature
//   MEM_ARB_RR_EN  when defined, simultaneous requests alternate between
//                  I and D (round robin). When undefined, D always wins
//                  because it belongs to the older instruction.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   i_req, i_addr              fetch request (level) and address
//   i_rdata, i_ready           registered fetch data, one-cycle done pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_mask            load/store request, direction, address,
//                              store data, byte enables
//   d_rdata, d_ready           registered load data, one-cycle done pulse
//   err                        pulses with ready when the access timed out
//   stall                      pipeline stall, combinational
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_mask        memory request side, held until mem_ack
//   mem_ack, mem_rdata         memory completion and read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ready,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_mask,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ready,
  output logic            err,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_mask,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  // Counter wide enough to hold TIMEOUT-1; at least one bit so the
  // declaration stays legal when the watchdog is disabled.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam bit WATCHDOG_ON = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE,
    GNT_I,
    GNT_D,
    DONE_I,
    DONE_D
  } arbState_t;

  arbState_t       state;
  arbState_t       stateNext;
  logic [CW-1:0]   waitCnt;
  logic            timeoutHit;
  logic            pickD;
  logic            inGrant;

  assign inGrant = (state == GNT_I) || (state == GNT_D);

  // Arbitration choice, only consulted while idle.
`ifdef MEM_ARB_RR_EN
  // lastGnt: 0 = I was granted last, 1 = D was granted last.
  logic lastGnt;

  always_comb begin
    pickD = d_req & (~i_req | ~lastGnt);
  end

  // Pointer moves on every grant entry, so a lone requester also updates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGnt <= 1'b0;
    end else if (state == IDLE) begin
      if (stateNext == GNT_D) begin
        lastGnt <= 1'b1;
      end else if (stateNext == GNT_I) begin
        lastGnt <= 1'b0;
      end
    end
  end
`else
  always_comb begin
    pickD = d_req;
  end
`endif

  // Next-state logic. An ack on the last allowed grant cycle wins over the
  // watchdog, so timeoutHit is only raised when mem_ack is low.
  always_comb begin
    stateNext  = state;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (pickD) begin
          stateNext = GNT_D;
        end else if (i_req) begin
          stateNext = GNT_I;
        end
      end
      GNT_I: begin
        if (mem_ack) begin
          stateNext = DONE_I;
        end else if (WATCHDOG_ON && (waitCnt == WAIT_LAST)) begin
          stateNext  = DONE_I;
          timeoutHit = 1'b1;
        end
      end
      GNT_D: begin
        if (mem_ack) begin
          stateNext = DONE_D;
        end else if (WATCHDOG_ON && (waitCnt == WAIT_LAST)) begin
          stateNext  = DONE_D;
          timeoutHit = 1'b1;
        end
      end
      DONE_I:  stateNext = IDLE;
      DONE_D:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Memory-side mux. Fields follow the granted requester live; requesters
  // hold their inputs, so these stay stable for the whole grant.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mask  = '0;
    case (state)
      GNT_I: begin
        mem_req  = 1'b1;
        mem_addr = i_addr;
        mem_mask = '1;
      end
      GNT_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_mask  = d_mask;
      end
      default: begin
      end
    endcase
  end

  // State register. Reset abandons any access without a ready pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Watchdog counter: zero outside the grant states, so it is already clear
  // on grant entry, and counts grant cycles that end without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (inGrant) begin
      if (!mem_ack) begin
        waitCnt <= waitCnt + CW'(1);
      end
    end else begin
      waitCnt <= '0;
    end
  end

  // Read-data registers. A timed-out read returns zero; a store never
  // touches d_rdata, whether it completed or timed out.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == GNT_I) begin
        if (mem_ack) begin
          i_rdata <= mem_rdata;
        end else if (timeoutHit) begin
          i_rdata <= '0;
        end
      end
      if ((state == GNT_D) && !d_we) begin
        if (mem_ack) begin
          d_rdata <= mem_rdata;
        end else if (timeoutHit) begin
          d_rdata <= '0;
        end
      end
    end
  end

  // err is remembered from the aborting grant cycle so it lines up with the
  // ready pulse in the following DONE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= timeoutHit;
    end
  end

  assign i_ready = (state == DONE_I);
  assign d_ready = (state == DONE_D);
  assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule
